// File: rtl/d_kes_elp_out_serializer.sv
// Captures the final KES error-locator polynomial, finds its degree by scanning
// the non-zero flags from the top down, then streams coefficients 0..T to Chien search.
module d_kes_elp_out_serializer #(
    parameter int GF_ORDER = 12,
    parameter int T        = 14,
    parameter int IDX_W    = 4
) (
    input  logic                         i_clk,
    input  logic                         i_nRESET_KES,
    input  logic                         i_stop_dec,
    input  logic                         i_elp_load,
    input  logic [(T+1)*GF_ORDER-1:0]    i_elp_coef,
    input  logic [T:0]                   i_elp_deg_chk,
    output logic                         o_buf_ready,
    output logic                         o_coef_valid,
    input  logic                         i_coef_ready,
    output logic [GF_ORDER-1:0]          o_coef,
    output logic [IDX_W-1:0]             o_coef_idx,
    output logic                         o_coef_last,
    output logic [IDX_W-1:0]             o_elp_deg,
    output logic                         o_elp_fail
);

    localparam logic [IDX_W-1:0] T_IDX = IDX_W'(T);

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_SCAN = 3'b010,
        ST_SEND = 3'b100
    } state_t;

    state_t                        state_q, state_d;
    logic [T:0][GF_ORDER-1:0]      coef_q, coef_d;
    logic [T:0]                    flag_q, flag_d;
    logic [IDX_W-1:0]              ptr_q, ptr_d;
    logic                          valid_q, valid_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [GF_ORDER-1:0]           out_coef_q, out_coef_d;
    logic                          last_q, last_d;
    logic [IDX_W-1:0]              deg_q, deg_d;
    logic                          fail_q, fail_d;

    logic                          accept;
    logic [IDX_W-1:0]              idx_inc;

    assign accept  = valid_q & i_coef_ready;
    assign idx_inc = idx_q + 1'b1;

    // NOTE: every _d gets its hold value first so no path through the case leaves a latch.
    always_comb begin
        state_d    = state_q;
        coef_d     = coef_q;
        flag_d     = flag_q;
        ptr_d      = ptr_q;
        valid_d    = valid_q;
        idx_d      = idx_q;
        out_coef_d = out_coef_q;
        last_d     = last_q;
        deg_d      = deg_q;
        fail_d     = fail_q;

        case (state_q)
            ST_IDLE: begin
                if (i_elp_load) begin
                    coef_d  = i_elp_coef;
                    flag_d  = i_elp_deg_chk;
                    ptr_d   = T_IDX;
                    deg_d   = '0;
                    fail_d  = ~i_elp_deg_chk[0];
                    state_d = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (flag_q[ptr_q] || ptr_q == '0) begin
                    // A degree-0 hit with flag[0] clear means no flag was set at all.
                    deg_d      = ptr_q;
                    fail_d     = fail_q | ~flag_q[ptr_q];
                    idx_d      = '0;
                    out_coef_d = coef_q[0];
                    last_d     = (T_IDX == '0);
                    state_d    = ST_SEND;
                end else begin
                    ptr_d = ptr_q - 1'b1;
                end
            end

            ST_SEND: begin
                // First SEND cycle primes the valid flop; beats start the cycle after.
                if (!valid_q) begin
                    valid_d = 1'b1;
                end else if (accept) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d      = idx_inc;
                        out_coef_d = coef_q[idx_inc];
                        last_d     = (idx_inc == T_IDX);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_nRESET_KES || i_stop_dec) begin
            state_q    <= ST_IDLE;
            // NOTE: the coefficient store is cleared too, so an aborted ELP never leaks into the next one.
            coef_q     <= '0;
            flag_q     <= '0;
            ptr_q      <= '0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            out_coef_q <= '0;
            last_q     <= 1'b0;
            deg_q      <= '0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            coef_q     <= coef_d;
            flag_q     <= flag_d;
            ptr_q      <= ptr_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            out_coef_q <= out_coef_d;
            last_q     <= last_d;
            deg_q      <= deg_d;
            fail_q     <= fail_d;
        end
    end

    assign o_buf_ready  = (state_q == ST_IDLE);
    assign o_coef_valid = valid_q;
    assign o_coef       = out_coef_q;
    assign o_coef_idx   = idx_q;
    assign o_coef_last  = last_q;
    assign o_elp_deg    = deg_q;
    assign o_elp_fail   = fail_q;

endmodule
